// File: rtl/srcd_pipe.sv
// Source-data holding stage: keeps the two most recent read phrases (srcd1 newest,
// srcd2 previous) and presents them as a pair to the source barrel shifter.
module srcd_pipe #(
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        prime,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] srcd1lo,
    output logic [31:0] srcd1hi,
    output logic [31:0] srcd2lo,
    output logic [31:0] srcd2hi,
    output logic [7:0]  beat_cnt
);

    localparam int unsigned PHRASE_W = 64;
    localparam int unsigned LONG_W   = 32;
    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                state_q,   state_d;
    logic                  out_valid_q, out_valid_d;
    logic                  prime_pending_q, prime_pending_d;
    logic [CNT_W-1:0]      beat_q,    beat_d;
    logic [PHRASE_W-1:0]   srcd1_q,   srcd1_d;
    logic [PHRASE_W-1:0]   srcd2_q,   srcd2_d;

    logic accept;
    logic consume;
    logic prime_eff;

    // Handshake terms; din_ready is the only combinational output
    always_comb begin
        din_ready = !flush && ((state_q != ST_FULL) || out_ready);
        accept    = din_valid && din_ready;
        consume   = out_valid_q && out_ready;
        prime_eff = prime || prime_pending_q;
    end

    // Next-state: flush dominates, then accept, then consume/prime bookkeeping
    always_comb begin
        state_d         = state_q;
        out_valid_d     = out_valid_q;
        prime_pending_d = prime_pending_q;
        beat_d          = beat_q;
        srcd1_d         = srcd1_q;
        srcd2_d         = srcd2_q;

        if (flush) begin
            state_d         = ST_EMPTY;
            out_valid_d     = 1'b0;
            // A prime arriving with the flush still applies to the next line
            prime_pending_d = prime;
            beat_d          = '0;
            if (ZERO_ON_FLUSH) begin
                srcd1_d = '0;
                srcd2_d = '0;
            end
        end else if (accept) begin
            srcd2_d = srcd1_q;
            srcd1_d = din;
            if (prime_eff) begin
                // Priming phrase only fills srcd1; no pair is emitted
                state_d         = ST_HELD;
                out_valid_d     = 1'b0;
                prime_pending_d = 1'b0;
            end else begin
                state_d     = ST_FULL;
                out_valid_d = 1'b1;
                if (beat_q != CNT_MAX) begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
        end else begin
            if (consume) begin
                // Keep srcd1/srcd2 so the next phrase pairs with srcd1
                state_d     = ST_HELD;
                out_valid_d = 1'b0;
            end
            if (prime) begin
                prime_pending_d = 1'b1;
            end
        end
    end

    // State and data registers
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_EMPTY;
            out_valid_q     <= 1'b0;
            prime_pending_q <= 1'b0;
            beat_q          <= '0;
            srcd1_q         <= '0;
            srcd2_q         <= '0;
        end else begin
            state_q         <= state_d;
            out_valid_q     <= out_valid_d;
            prime_pending_q <= prime_pending_d;
            beat_q          <= beat_d;
            srcd1_q         <= srcd1_d;
            srcd2_q         <= srcd2_d;
        end
    end

    // Registered outputs split into phrase halves
    always_comb begin
        out_valid = out_valid_q;
        beat_cnt  = beat_q;
        srcd1lo   = srcd1_q[LONG_W-1:0];
        srcd1hi   = srcd1_q[PHRASE_W-1:LONG_W];
        srcd2lo   = srcd2_q[LONG_W-1:0];
        srcd2hi   = srcd2_q[PHRASE_W-1:LONG_W];
    end

endmodule

// File: tb/tb_srcd_pipe.sv
// Directed bench for srcd_pipe: vector table plus a saturation sequence.
module tb_srcd_pipe;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [63:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        prime;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] srcd1lo, srcd1hi, srcd2lo, srcd2hi;
    logic [7:0]  beat_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    srcd_pipe #(.ZERO_ON_FLUSH(1'b1)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .prime     (prime),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .srcd1lo   (srcd1lo),
        .srcd1hi   (srcd1hi),
        .srcd2lo   (srcd2lo),
        .srcd2hi   (srcd2hi),
        .beat_cnt  (beat_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        dv;
        logic [63:0] d;
        logic        pr;
        logic        fl;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_ov;
        logic [63:0] exp_s1;
        logic [63:0] exp_s2;
        logic [7:0]  exp_beat;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    localparam logic [63:0] P1 = 64'h1111_1111_2222_2222;
    localparam logic [63:0] P2 = 64'h3333_3333_4444_4444;
    localparam logic [63:0] PA = 64'hA;
    localparam logic [63:0] PB = 64'hB;
    localparam logic [63:0] PC = 64'hCCCC_0000_0000_000C;
    localparam logic [63:0] PD = 64'hDDDD_0000_0000_000D;
    localparam logic [63:0] PE = 64'hEEEE_0000_0000_000E;
    localparam logic [63:0] PF = 64'hFFFF_0000_0000_000F;

    function automatic vec_t mk(input logic dv, input logic [63:0] d, input logic pr,
                                input logic fl, input logic ordy, input logic exp_rdy,
                                input logic exp_ov, input logic [63:0] exp_s1,
                                input logic [63:0] exp_s2, input logic [7:0] exp_beat);
        vec_t v;
        v.dv = dv; v.d = d; v.pr = pr; v.fl = fl; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov;
        v.exp_s1 = exp_s1; v.exp_s2 = exp_s2; v.exp_beat = exp_beat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic [63:0] s1,
                              input logic [63:0] s2, input logic [7:0] bc);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, " srcd1"}, {srcd1hi, srcd1lo}, s1);
        chk({tag, " srcd2"}, {srcd2hi, srcd2lo}, s2);
        chk({tag, " beat_cnt"}, 64'(beat_cnt), 64'(bc));
    endtask

    initial begin
        //            dv  din  pr  fl  ordy | rdy ov  srcd1 srcd2 beat
        vecs[0]  = mk(1, P1,    0, 0, 1,  1, 1, P1, 64'h0, 8'd1);
        vecs[1]  = mk(1, P2,    0, 0, 1,  1, 1, P2, P1,    8'd2);
        vecs[2]  = mk(1, 64'h5555, 0, 1, 1, 0, 0, 64'h0, 64'h0, 8'd0);
        vecs[3]  = mk(1, PA,    1, 0, 1,  1, 0, PA, 64'h0, 8'd0);
        vecs[4]  = mk(1, PB,    0, 0, 1,  1, 1, PB, PA,    8'd1);
        vecs[5]  = mk(1, PC,    0, 0, 0,  0, 1, PB, PA,    8'd1);
        vecs[6]  = mk(1, PC,    0, 0, 0,  0, 1, PB, PA,    8'd1);
        vecs[7]  = mk(1, PC,    0, 0, 0,  0, 1, PB, PA,    8'd1);
        vecs[8]  = mk(1, PC,    0, 0, 0,  0, 1, PB, PA,    8'd1);
        vecs[9]  = mk(1, PC,    0, 0, 0,  0, 1, PB, PA,    8'd1);
        vecs[10] = mk(1, PC,    0, 0, 1,  1, 1, PC, PB,    8'd2);
        vecs[11] = mk(0, 64'h0, 0, 0, 1,  1, 0, PC, PB,    8'd2);
        vecs[12] = mk(0, 64'h0, 0, 0, 0,  1, 0, PC, PB,    8'd2);
        vecs[13] = mk(1, PD,    0, 0, 0,  1, 1, PD, PC,    8'd3);
        vecs[14] = mk(0, 64'h0, 1, 0, 0,  0, 1, PD, PC,    8'd3);
        vecs[15] = mk(0, 64'h0, 1, 0, 1,  1, 0, PD, PC,    8'd3);
        vecs[16] = mk(1, PE,    0, 0, 1,  1, 0, PE, PD,    8'd3);
        vecs[17] = mk(1, PF,    0, 0, 1,  1, 1, PF, PE,    8'd4);
        vecs[18] = mk(1, 64'h77, 1, 1, 1, 0, 0, 64'h0, 64'h0, 8'd0);
        vecs[19] = mk(1, 64'h88, 0, 0, 1, 1, 0, 64'h88, 64'h0, 8'd0);
        vecs[20] = mk(1, 64'h99, 0, 0, 1, 1, 1, 64'h99, 64'h88, 8'd1);

        reset = 1'b1; din = '0; din_valid = 0; prime = 0; flush = 0; out_ready = 0;
        repeat (3) @(posedge sys_clk);
        #1 reset = 1'b0;
        #1;
        check_outs("reset", 1'b0, 64'h0, 64'h0, 8'd0);
        chk("reset din_ready", 64'(din_ready), 64'd1);

        for (int i = 0; i < NVEC; i++) begin
            din = vecs[i].d; din_valid = vecs[i].dv; prime = vecs[i].pr;
            flush = vecs[i].fl; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d din_ready", i), 64'(din_ready), 64'(vecs[i].exp_rdy));
            @(posedge sys_clk);
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_s1,
                       vecs[i].exp_s2, vecs[i].exp_beat);
        end

        // Saturation: flush, then 300 unprimed beats back to back
        din_valid = 0; prime = 0; flush = 1; out_ready = 1;
        @(posedge sys_clk);
        #1 flush = 0;
        check_outs("sat flush", 1'b0, 64'h0, 64'h0, 8'd0);
        for (int i = 1; i <= 300; i++) begin
            logic [63:0] cur, prev;
            logic [7:0]  bc;
            cur  = {32'(i) ^ 32'hA5A5_0000, 32'(i)};
            prev = (i == 1) ? 64'h0 : {32'(i - 1) ^ 32'hA5A5_0000, 32'(i - 1)};
            bc   = (i >= 255) ? 8'd255 : 8'(i);
            din = cur; din_valid = 1;
            @(posedge sys_clk);
            #1;
            chk($sformatf("sat%0d srcd1", i), {srcd1hi, srcd1lo}, cur);
            chk($sformatf("sat%0d srcd2", i), {srcd2hi, srcd2lo}, prev);
            if (i >= 253) begin
                chk($sformatf("sat%0d beat_cnt", i), 64'(beat_cnt), 64'(bc));
                chk($sformatf("sat%0d out_valid", i), 64'(out_valid), 64'd1);
            end
        end
        din_valid = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
